// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM encoding,
// the opcodes decoded downstream for redirects, the default bubble word and
// the PC increment helper.
// -----------------------------------------------------------------------------
package if_stage_pkg;

    // S_REQ  : a fetch request is outstanding on the instruction memory
    // S_HOLD : a fetched word is parked in the hold buffer while stalled
    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [5:0]  op_JUMP      = 6'd2;
    localparam logic [5:0]  op_BEQ       = 6'd4;

    // sll $0,$0,0 -- architectural no-op
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    // Sequential PC; wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory handshake between the fetch stage (master) and the
// instruction memory (slave).
//   imem_req_o   : fetch request valid (master -> memory)
//   imem_addr_o  : fetch address, stable while a request waits for ready
//   imem_ready_i : memory returns imem_data_i in this cycle
//   imem_data_i  : fetched instruction word
// -----------------------------------------------------------------------------
interface if_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with stall and flush.
// Priority: rst_i > flush_i > stall_i > load_i; with none of them active the
// register takes a bubble.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : replace contents with a bubble
//   stall_i           : hold contents
//   load_i            : capture instr_i / pc4_i as a valid instruction
//   instr_o, pc4_o,
//   valid_o           : register contents; instr_o is BUBBLE_INSTR when invalid
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // pc4 is left untouched on a bubble: a following jump still forms its
    // region bits from the last real pc+4.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= BUBBLE_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= BUBBLE_INSTR;
            valid_q <= 1'b0;
        end else if (stall_i) begin
            instr_q <= instr_q;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end else begin
            instr_q <= BUBBLE_INSTR;
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC register, fetch FSM with a one-word hold buffer,
// branch/jump redirect (with deferral while a fetch is still in flight) and
// the IF/ID pipeline register.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   stall_i               : freeze PC and IF/ID
//   flush_i               : bubble IF/ID only
//   branch_taken_i,
//   branch_target_i       : taken BEQ from ID and its target
//   jump_i, jump_index_i  : J from ID and its 26-bit index (wins over branch)
//   imem                  : instruction-memory handshake (master side)
//   pc_o                  : current fetch PC
//   if_id_instr_o/_pc4_o/
//   if_id_valid_o         : IF/ID register outputs
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_target_i,
    input  logic               jump_i,
    input  logic [25:0]        jump_index_i,
    if_stage_if.master         imem,
    output logic [31:0]        pc_o,
    output logic [31:0]        if_id_instr_o,
    output logic [31:0]        if_id_pc4_o,
    output logic               if_id_valid_o
);
    import if_stage_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic         redirect_pending_q, redirect_pending_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         ifid_flush;
    logic         ifid_load;
    logic [31:0]  ifid_instr;

    assign redirect        = jump_i | branch_taken_i;
    assign redirect_target = jump_i ? {if_id_pc4_o[31:28], jump_index_i, 2'b00}
                                    : branch_target_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= S_REQ;
            pc_q               <= RESET_PC;
            hold_q             <= 32'h0;
            redirect_pending_q <= 1'b0;
            redirect_pc_q      <= 32'h0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            hold_q             <= hold_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_pc_q      <= redirect_pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        hold_d             = hold_q;
        redirect_pending_d = redirect_pending_q;
        redirect_pc_d      = redirect_pc_q;

        if (redirect) begin
            // Redirect outranks stall. While a fetch is still in flight the
            // address must stay put, so the target is parked until the
            // (now stale) word comes back and is thrown away.
            if (state_q == S_HOLD) begin
                pc_d    = redirect_target;
                state_d = S_REQ;
                hold_d  = 32'h0;
            end else if (imem.imem_ready_i) begin
                pc_d               = redirect_target;
                redirect_pending_d = 1'b0;
            end else begin
                redirect_pending_d = 1'b1;
                redirect_pc_d      = redirect_target;
            end
        end else if (!flush_i) begin
            // A lone flush only bubbles IF/ID; fetch state is left alone.
            unique case (state_q)
                S_REQ: begin
                    if (imem.imem_ready_i) begin
                        if (redirect_pending_q) begin
                            pc_d               = redirect_pc_q;
                            redirect_pending_d = 1'b0;
                        end else if (stall_i) begin
                            hold_d  = imem.imem_data_i;
                            state_d = S_HOLD;
                        end else begin
                            pc_d = pc_plus4(pc_q);
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        pc_d    = pc_plus4(pc_q);
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs and IF/ID control
    always_comb begin
        imem.imem_req_o  = (state_q == S_REQ);
        imem.imem_addr_o = pc_q;
        ifid_flush       = redirect | flush_i;
        ifid_load        = 1'b0;
        ifid_instr       = imem.imem_data_i;
        if (state_q == S_HOLD) begin
            ifid_load  = 1'b1;
            ifid_instr = hold_q;
        end else begin
            // A word answering a superseded address is never loaded.
            ifid_load = imem.imem_ready_i & ~redirect_pending_q;
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR (BUBBLE_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (ifid_flush),
        .stall_i (stall_i),
        .load_i  (ifid_load),
        .instr_i (ifid_instr),
        .pc4_i   (pc_plus4(pc_q)),
        .instr_o (if_id_instr_o),
        .pc4_o   (if_id_pc4_o),
        .valid_o (if_id_valid_o)
    );

    assign pc_o = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed steps followed by a randomized phase; every cycle the DUT outputs
// are compared with a behavioural model of the fetch stage kept in the bench.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] BUBBLE = 32'h0000_0000;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch;
    logic [31:0] btarget;
    logic        jump;
    logic [25:0] jidx;
    logic [31:0] pc_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;

    int checks = 0;
    int errors = 0;

    if_stage_if imem ();

    if_stage #(
        .RESET_PC     (RST_PC),
        .BUBBLE_INSTR (BUBBLE)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_taken_i  (branch),
        .branch_target_i (btarget),
        .jump_i          (jump),
        .jump_index_i    (jidx),
        .imem            (imem),
        .pc_o            (pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_valid_o   (if_id_valid_o)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem.imem_data_i = mem_word(imem.imem_addr_o);

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_holding;
    logic [31:0] m_hold_word;
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    task automatic m_bubble();
        m_valid = 1'b0;
        m_instr = BUBBLE;
    endtask

    task automatic m_deliver(input logic [31:0] word);
        m_valid = 1'b1;
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
    endtask

    // Applies one clock edge worth of rules to the model using current inputs.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = jump ? {m_pc4[31:28], jidx, 2'b00} : btarget;
        if (rst) begin
            m_pc = RST_PC; m_holding = 0; m_hold_word = 0; m_pend = 0;
            m_pend_pc = 0; m_valid = 0; m_instr = BUBBLE; m_pc4 = 0;
        end else if (jump || branch) begin
            m_bubble();
            if (m_holding) begin
                m_pc = tgt; m_holding = 0;
            end else if (imem.imem_ready_i) begin
                m_pc = tgt; m_pend = 0;
            end else begin
                m_pend = 1; m_pend_pc = tgt;
            end
        end else if (flush) begin
            m_bubble();
        end else if (m_holding) begin
            if (!stall) begin
                m_deliver(m_hold_word);
                m_holding = 0;
            end
        end else if (imem.imem_ready_i && m_pend) begin
            m_pc = m_pend_pc; m_pend = 0;
            if (!stall) m_bubble();
        end else if (imem.imem_ready_i && !stall) begin
            m_deliver(mem_word(m_pc));
        end else if (imem.imem_ready_i) begin
            m_hold_word = mem_word(m_pc); m_holding = 1;
        end else if (!stall) begin
            m_bubble();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("pc", pc_o, m_pc);
        check("req", {31'b0, imem.imem_req_o}, {31'b0, ~m_holding});
        if (!m_holding) check("addr", imem.imem_addr_o, m_pc);
        check("valid", {31'b0, if_id_valid_o}, {31'b0, m_valid});
        check("instr", if_id_instr_o, m_instr);
        check("pc4", if_id_pc4_o, m_pc4);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        $display("t=%0t rst=%b stl=%b fl=%b br=%b j=%b rdy=%b | pc=%h req=%b v=%b instr=%h pc4=%h",
                 $time, rst, stall, flush, branch, jump, imem.imem_ready_i,
                 pc_o, imem.imem_req_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o);
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; branch = 0; jump = 0;
        btarget = 32'h0; jidx = 26'h0;
    endtask

    logic [31:0] saved;

    initial begin
        idle();
        rst = 1;
        imem.imem_ready_i = 1'b0;
        m_pc = 0; m_holding = 0; m_hold_word = 0; m_pend = 0;
        m_pend_pc = 0; m_valid = 0; m_instr = 0; m_pc4 = 0;

        // Reset
        step();
        step();
        rst = 0;
        check("rst_pc", pc_o, RST_PC);
        check("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("rst_instr", if_id_instr_o, BUBBLE);
        check("rst_pc4", if_id_pc4_o, 32'h0);
        check("rst_req", {31'b0, imem.imem_req_o}, 32'h1);

        // Zero-wait sequential fetch
        imem.imem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", pc_o, 32'(i * 4));
            step();
            check("seq_pc4", if_id_pc4_o, 32'(i * 4 + 4));
            check("seq_instr", if_id_instr_o, mem_word(32'(i * 4)));
        end

        // Stall during a ready cycle: word parked, no refetch while held
        saved = pc_o;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_req", {31'b0, imem.imem_req_o}, 32'h0);
            check("hold_pc", pc_o, saved);
        end
        stall = 0;
        step();
        check("hold_release_instr", if_id_instr_o, mem_word(saved));
        check("hold_release_valid", {31'b0, if_id_valid_o}, 32'h1);
        check("hold_release_pc", pc_o, saved + 32'd4);

        // Jump with if_id_pc4 = 0x0040_0008
        branch = 1; btarget = 32'h0040_0004;
        step();
        branch = 0;
        step();
        check("jmp_setup_pc4", if_id_pc4_o, 32'h0040_0008);
        jump = 1; jidx = 26'h000_0010;
        step();
        jump = 0;
        check("jmp_pc", pc_o, 32'h0000_0040);
        check("jmp_bubble", {31'b0, if_id_valid_o}, 32'h0);
        step();
        check("jmp_resume_valid", {31'b0, if_id_valid_o}, 32'h1);

        // Branch during a 2-wait-state fetch: returning word dropped
        saved = pc_o;
        imem.imem_ready_i = 1'b0;
        branch = 1; btarget = 32'h0000_0100;
        step();
        branch = 0;
        check("wait_addr_held", imem.imem_addr_o, saved);
        step();
        imem.imem_ready_i = 1'b1;
        step();
        check("drop_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("drop_addr", imem.imem_addr_o, 32'h0000_0100);

        // Second redirect while pending overwrites the target
        imem.imem_ready_i = 1'b0;
        branch = 1; btarget = 32'h0000_0200;
        step();
        btarget = 32'h0000_0300;
        step();
        branch = 0; imem.imem_ready_i = 1'b1;
        step();
        check("pend_overwrite_pc", pc_o, 32'h0000_0300);

        // Jump and branch together: jump wins; redirect beats stall
        step();
        saved = if_id_pc4_o;
        jump = 1; jidx = 26'h000_0123; branch = 1; btarget = 32'h0000_0500;
        step();
        jump = 0;
        check("jmp_prio_pc", pc_o, {m_pc4[31:28], 26'h000_0123, 2'b00});
        stall = 1; btarget = 32'h0000_0600;
        step();
        stall = 0; branch = 0;
        check("stall_redirect_pc", pc_o, 32'h0000_0600);
        check("stall_redirect_valid", {31'b0, if_id_valid_o}, 32'h0);

        // Flush alone: bubble, pc unchanged
        step();
        saved = pc_o;
        flush = 1;
        step();
        flush = 0;
        check("flush_pc", pc_o, saved);
        check("flush_valid", {31'b0, if_id_valid_o}, 32'h0);

        // Reset in the middle of a wait at pc 0x20
        branch = 1; btarget = 32'h0000_0020;
        step();
        branch = 0; imem.imem_ready_i = 1'b0;
        step();
        rst = 1;
        step();
        rst = 0;
        check("midrst_pc", pc_o, RST_PC);
        check("midrst_valid", {31'b0, if_id_valid_o}, 32'h0);

        // PC wrap
        imem.imem_ready_i = 1'b1;
        branch = 1; btarget = 32'hFFFF_FFFC;
        step();
        branch = 0;
        step();
        check("wrap_pc", pc_o, 32'h0000_0000);
        check("wrap_pc4", if_id_pc4_o, 32'h0000_0000);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            rst               = ($urandom_range(0, 49) == 0);
            stall             = ($urandom_range(0, 3) == 0);
            flush             = ($urandom_range(0, 9) == 0);
            branch            = ($urandom_range(0, 7) == 0);
            jump              = ($urandom_range(0, 9) == 0);
            btarget           = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            jidx              = 26'($urandom());
            imem.imem_ready_i = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
